// File: rtl/multicore_pkg.sv
// -----------------------------------------------------------------------------
// multicore_pkg
// Shared geometry and types for the multicore instruction-fetch path.
//   LINES_PER_BLK : number of instruction-cache lines
//   LINE_SIZE     : line width in bits (one instruction per line)
//   INST_SIZE     : instruction width in bits
//   OFFSET        : byte-offset bits inside one instruction word
//   IDX_W / TAG_W : address split for a 32-bit byte address
// -----------------------------------------------------------------------------
package multicore_pkg;

   localparam int LINES_PER_BLK = 256;
   localparam int LINE_SIZE     = 32;
   localparam int INST_SIZE     = 32;
   localparam int OFFSET        = 2;
   localparam int IDX_W         = $clog2(LINES_PER_BLK);
   localparam int TAG_W         = 32 - IDX_W - OFFSET;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      LOOKUP      = 2'd1,
      REFILL_REQ  = 2'd2,
      REFILL_WAIT = 2'd3
   } icache_state_t;

   // Saturating increment: performance counters stick at all-ones.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      logic [31:0] r;
      if (v == 32'hFFFF_FFFF) begin
         r = v;
      end else begin
         r = v + 32'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/icache_array.sv
// -----------------------------------------------------------------------------
// icache_array
// Single-port synchronous tag+data RAM for the direct-mapped icache.
// One-cycle read latency; a write also presents the written entry on the
// read port in the following cycle (write-first). Contents are not reset so
// the array can map onto block RAM.
// Ports:
//   clk   : clock
//   en    : port enable (read or write this cycle)
//   we    : write enable (qualified by en)
//   addr  : line index
//   wtag  : tag to write
//   wdata : instruction word to write
//   rtag  : tag read (valid the cycle after en)
//   rdata : data read (valid the cycle after en)
// -----------------------------------------------------------------------------
module icache_array #(
   parameter int DEPTH  = 256,
   parameter int AW     = 8,
   parameter int TAG_W  = 22,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [TAG_W-1:0]  wtag,
   input  logic [DATA_W-1:0] wdata,
   output logic [TAG_W-1:0]  rtag,
   output logic [DATA_W-1:0] rdata
);

   localparam int ENTRY_W = TAG_W + DATA_W;

   logic [ENTRY_W-1:0] mem_r [DEPTH];
   logic [ENTRY_W-1:0] q_r;

   // RAM write and registered read port (write-first on a write).
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_r[addr] <= {wtag, wdata};
            q_r         <= {wtag, wdata};
         end else begin
            q_r         <= mem_r[addr];
         end
      end
   end

   assign rtag  = q_r[ENTRY_W-1:DATA_W];
   assign rdata = q_r[DATA_W-1:0];

endmodule

// File: rtl/icache_dm.sv
// -----------------------------------------------------------------------------
// icache_dm
// Direct-mapped instruction cache, one instruction per line. One request is
// in flight at a time: IDLE accepts, LOOKUP resolves hit/miss/misaligned,
// REFILL_REQ / REFILL_WAIT fetch a single word from instruction memory.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   flush            : level, invalidates every line (acted on in IDLE only)
//   core_req_valid   : fetch request present
//   core_req_ready   : request can be accepted this cycle
//   core_addr        : byte address of the instruction
//   core_resp_valid  : one-cycle response pulse
//   core_resp_data   : instruction word (0 when no response)
//   core_resp_err    : misaligned request flag
//   mem_req_valid    : refill request to memory
//   mem_req_ready    : memory accepts the refill request
//   mem_req_addr     : word-aligned refill address
//   mem_resp_valid   : refill data valid
//   mem_resp_data    : refill word
//   hit_count        : saturating hit counter
//   miss_count       : saturating miss counter
// -----------------------------------------------------------------------------
module icache_dm
   import multicore_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LINES  = LINES_PER_BLK,
   parameter int DATA_W = INST_SIZE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              core_req_valid,
   output logic              core_req_ready,
   input  logic [ADDR_W-1:0] core_addr,
   output logic              core_resp_valid,
   output logic [DATA_W-1:0] core_resp_data,
   output logic              core_resp_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);

   localparam int IW = $clog2(LINES);
   localparam int TW = ADDR_W - IW - OFFSET;

   icache_state_t     state_r;
   icache_state_t     state_s;
   logic [ADDR_W-1:0] addr_r;
   logic [LINES-1:0]  valid_r;
   logic [31:0]       hit_count_r;
   logic [31:0]       miss_count_r;

   logic [IW-1:0]     idx_in_s;
   logic [IW-1:0]     idx_s;
   logic [TW-1:0]     tag_s;
   logic              misaligned_s;
   logic              hit_s;
   logic              accept_s;
   logic              fill_s;

   logic              arr_en_s;
   logic [IW-1:0]     arr_addr_s;
   logic [TW-1:0]     arr_tag_s;
   logic [DATA_W-1:0] arr_data_s;

   logic              resp_valid_s;
   logic [DATA_W-1:0] resp_data_s;
   logic              resp_err_s;
   logic              mem_req_valid_s;
   logic [ADDR_W-1:0] mem_req_addr_s;
   logic              hit_inc_s;
   logic              miss_inc_s;

   assign idx_in_s     = core_addr[OFFSET+IW-1:OFFSET];
   assign idx_s        = addr_r[OFFSET+IW-1:OFFSET];
   assign tag_s        = addr_r[ADDR_W-1:OFFSET+IW];
   assign misaligned_s = (addr_r[OFFSET-1:0] != {OFFSET{1'b0}});
   assign hit_s        = valid_r[idx_s] && (arr_tag_s == tag_s);

   // Ready is withheld during reset and while a flush is pending so that a
   // flush always wins against a simultaneous request.
   assign core_req_ready = (state_r == IDLE) && !flush && !rst;
   assign accept_s       = core_req_valid && core_req_ready;
   assign fill_s         = (state_r == REFILL_WAIT) && mem_resp_valid && !rst;

   // The array is read at accept time so the tag/data are ready in LOOKUP;
   // the only write is the refill, which uses the registered index.
   assign arr_en_s   = accept_s || fill_s;
   assign arr_addr_s = fill_s ? idx_s : idx_in_s;

   icache_array #(
      .DEPTH  (LINES),
      .AW     (IW),
      .TAG_W  (TW),
      .DATA_W (DATA_W)
   ) u_array (
      .clk   (clk),
      .en    (arr_en_s),
      .we    (fill_s),
      .addr  (arr_addr_s),
      .wtag  (tag_s),
      .wdata (mem_resp_data),
      .rtag  (arr_tag_s),
      .rdata (arr_data_s)
   );

   // Next-state and response/memory-request decode.
   always_comb begin
      state_s         = state_r;
      resp_valid_s    = 1'b0;
      resp_data_s     = {DATA_W{1'b0}};
      resp_err_s      = 1'b0;
      mem_req_valid_s = 1'b0;
      mem_req_addr_s  = {ADDR_W{1'b0}};
      hit_inc_s       = 1'b0;
      miss_inc_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s = LOOKUP;
            end else begin
               state_s = IDLE;
            end
         end
         LOOKUP: begin
            if (misaligned_s) begin
               resp_valid_s = 1'b1;
               resp_err_s   = 1'b1;
               state_s      = IDLE;
            end else if (hit_s) begin
               resp_valid_s = 1'b1;
               resp_data_s  = arr_data_s;
               hit_inc_s    = 1'b1;
               state_s      = IDLE;
            end else begin
               miss_inc_s   = 1'b1;
               state_s      = REFILL_REQ;
            end
         end
         REFILL_REQ: begin
            mem_req_valid_s = 1'b1;
            mem_req_addr_s  = {addr_r[ADDR_W-1:OFFSET], {OFFSET{1'b0}}};
            if (mem_req_ready) begin
               state_s = REFILL_WAIT;
            end else begin
               state_s = REFILL_REQ;
            end
         end
         REFILL_WAIT: begin
            if (mem_resp_valid) begin
               resp_valid_s = 1'b1;
               resp_data_s  = mem_resp_data;
               state_s      = IDLE;
            end else begin
               state_s      = REFILL_WAIT;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register and captured request address.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         addr_r  <= {ADDR_W{1'b0}};
      end else begin
         state_r <= state_s;
         if (accept_s) begin
            addr_r <= core_addr;
         end else begin
            addr_r <= addr_r;
         end
      end
   end

   // Valid bits: flush only acts in IDLE, so a refill in flight completes
   // first and its line is then cleared by the still-asserted flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= {LINES{1'b0}};
      end else if ((state_r == IDLE) && flush) begin
         valid_r <= {LINES{1'b0}};
      end else if (fill_s) begin
         valid_r[idx_s] <= 1'b1;
      end else begin
         valid_r <= valid_r;
      end
   end

   // Saturating hit/miss performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count_r  <= 32'd0;
         miss_count_r <= 32'd0;
      end else begin
         if (hit_inc_s) begin
            hit_count_r <= sat_inc(hit_count_r);
         end else begin
            hit_count_r <= hit_count_r;
         end
         if (miss_inc_s) begin
            miss_count_r <= sat_inc(miss_count_r);
         end else begin
            miss_count_r <= miss_count_r;
         end
      end
   end

   assign core_resp_valid = resp_valid_s;
   assign core_resp_data  = resp_data_s;
   assign core_resp_err   = resp_err_s;
   assign mem_req_valid   = mem_req_valid_s;
   assign mem_req_addr    = mem_req_addr_s;
   assign hit_count       = hit_count_r;
   assign miss_count      = miss_count_r;

endmodule

// File: tb/tb_icache_dm.sv
// -----------------------------------------------------------------------------
// tb_icache_dm
// Directed scoreboard bench for icache_dm. The driver pushes the expected
// response (data, err, due cycle) when a request is accepted; a monitor on the
// falling edge pops and compares every response. A small memory model answers
// refills and checks refill addresses against an expected-address queue.
// -----------------------------------------------------------------------------
module tb_icache_dm;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
      logic [31:0] due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        core_req_valid;
   logic        core_req_ready;
   logic [31:0] core_addr;
   logic        core_resp_valid;
   logic [31:0] core_resp_data;
   logic        core_resp_err;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] cyc = 32'd0;

   exp_t        sb[$];
   logic [31:0] memq[$];

   // memory model controls
   int          req_wait = 0;
   int          wait_cnt = 0;
   bit          resp_hold = 1'b0;
   bit          stale_req = 1'b0;
   logic        mem_hs;
   logic [31:0] mem_hs_addr;
   logic [31:0] mem_exp_addr;

   icache_dm dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .core_req_valid  (core_req_valid),
      .core_req_ready  (core_req_ready),
      .core_addr       (core_addr),
      .core_resp_valid (core_resp_valid),
      .core_resp_data  (core_resp_data),
      .core_resp_err   (core_resp_err),
      .mem_req_valid   (mem_req_valid),
      .mem_req_ready   (mem_req_ready),
      .mem_req_addr    (mem_req_addr),
      .mem_resp_valid  (mem_resp_valid),
      .mem_resp_data   (mem_resp_data),
      .hit_count       (hit_count),
      .miss_count      (miss_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 32'd1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0040: return 32'h0010_0093;
         32'h0000_0440: return 32'h0020_0113;
         default:       return 32'hBAD0_0000;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Instruction memory model: request handshake, refill response, stale pulse.
   always @(posedge clk) begin
      mem_hs      = mem_req_valid && mem_req_ready;
      mem_hs_addr = mem_req_addr;
      #1;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;
      if (mem_hs) begin
         checks++;
         if (memq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_mem_req actual=%h expected=none", mem_hs_addr);
         end else begin
            mem_exp_addr = memq.pop_front();
            if (mem_hs_addr !== mem_exp_addr) begin
               errors++;
               $display("FAIL mem_req_addr actual=%h expected=%h", mem_hs_addr, mem_exp_addr);
            end
         end
         if (!resp_hold) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(mem_hs_addr);
         end
      end else if (stale_req) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = 32'hDEAD_BEEF;
         stale_req      = 1'b0;
      end
      if (mem_req_valid) begin
         if (wait_cnt < req_wait) begin
            mem_req_ready = 1'b0;
            wait_cnt++;
         end else begin
            mem_req_ready = 1'b1;
         end
      end else begin
         wait_cnt      = 0;
         mem_req_ready = (req_wait == 0);
      end
   end

   // Response monitor: compare each response against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (core_resp_valid) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp actual=%h err=%0d expected=none", core_resp_data, core_resp_err);
         end else begin
            e = sb.pop_front();
            if (core_resp_data !== e.data || core_resp_err !== e.err || cyc !== e.due) begin
               errors++;
               $display("FAIL resp actual=%h/err%0d/cyc%0d expected=%h/err%0d/cyc%0d",
                        core_resp_data, core_resp_err, cyc, e.data, e.err, e.due);
            end
         end
      end else begin
         if (sb.size() > 0 && cyc > sb[0].due) begin
            checks++;
            errors++;
            e = sb.pop_front();
            $display("FAIL missing_resp actual=none expected=%h at cyc%0d", e.data, e.due);
         end
         if (core_resp_data !== 32'h0 || core_resp_err !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL idle_resp_zero actual=%h/%0d expected=0/0", core_resp_data, core_resp_err);
         end
      end
   end

   // Issue one request, wait for acceptance, and queue the expected response.
   task automatic read_req(input logic [31:0] a, input logic [31:0] d, input logic e,
                           input int lat, input bit exp_mem);
      exp_t x;
      bit   got;
      got            = 1'b0;
      core_req_valid = 1'b1;
      core_addr      = a;
      if (exp_mem) memq.push_back({a[31:2], 2'b00});
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (core_req_ready) begin
            got = 1'b1;
            break;
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL accept_timeout actual=not_ready expected=ready addr=%h", a);
      end else begin
         x.data = d;
         x.err  = e;
         x.due  = cyc + lat;
         sb.push_back(x);
      end
      @(posedge clk); #1;
      core_req_valid = 1'b0;
      core_addr      = 32'h0;
   endtask

   // Wait until every expected response and refill has been seen.
   task automatic wait_done();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && memq.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL drain_timeout actual=%0d/%0d pending expected=0/0", sb.size(), memq.size());
         sb.delete();
         memq.delete();
      end
      @(posedge clk); #1;
   endtask

   initial begin
      bit got;
      int stall;
      rst            = 1'b1;
      flush          = 1'b0;
      core_req_valid = 1'b0;
      core_addr      = 32'h0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ctrl", {27'd0, core_req_ready, core_resp_valid, core_resp_err, mem_req_valid, 1'b0}, 32'd0);
      chk("reset_resp_data", core_resp_data, 32'h0);
      chk("reset_mem_addr", mem_req_addr, 32'h0);
      chk("reset_hit", hit_count, 32'd0);
      chk("reset_miss", miss_count, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", {31'd0, core_req_ready}, 32'd1);
      @(posedge clk); #1;

      // cold miss, then hit
      read_req(32'h0000_0040, 32'h0010_0093, 1'b0, 3, 1'b1);
      wait_done();
      chk("cold_miss_cnt", miss_count, 32'd1);
      chk("cold_hit_cnt", hit_count, 32'd0);
      read_req(32'h0000_0040, 32'h0010_0093, 1'b0, 1, 1'b0);
      wait_done();
      chk("hit_cnt", hit_count, 32'd1);

      // conflict eviction on index 0x10
      read_req(32'h0000_0440, 32'h0020_0113, 1'b0, 3, 1'b1);
      wait_done();
      read_req(32'h0000_0040, 32'h0010_0093, 1'b0, 3, 1'b1);
      wait_done();
      chk("evict_miss_cnt", miss_count, 32'd3);

      // misaligned
      read_req(32'h0000_0042, 32'h0, 1'b1, 1, 1'b0);
      wait_done();
      chk("misaligned_hit_cnt", hit_count, 32'd1);
      chk("misaligned_miss_cnt", miss_count, 32'd3);

      // flush in IDLE, then miss
      flush = 1'b1;
      @(negedge clk);
      chk("flush_ready_low", {31'd0, core_req_ready}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      read_req(32'h0000_0040, 32'h0010_0093, 1'b0, 3, 1'b1);
      wait_done();
      chk("flush_miss_cnt", miss_count, 32'd4);
      read_req(32'h0000_0040, 32'h0010_0093, 1'b0, 1, 1'b0);
      wait_done();
      chk("refilled_hit_cnt", hit_count, 32'd2);

      // flush and request together: flush wins, request accepted next cycle
      flush          = 1'b1;
      core_req_valid = 1'b1;
      core_addr      = 32'h0000_0040;
      @(negedge clk);
      chk("flush_req_ready_low", {31'd0, core_req_ready}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      read_req(32'h0000_0040, 32'h0010_0093, 1'b0, 3, 1'b1);
      wait_done();
      chk("flush_req_miss_cnt", miss_count, 32'd5);

      // stalled refill, reset in REFILL_WAIT, stale response afterward
      req_wait       = 5;
      resp_hold      = 1'b1;
      core_req_valid = 1'b1;
      core_addr      = 32'h0000_0440;
      memq.push_back(32'h0000_0440);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (core_req_ready) begin
            got = 1'b1;
            break;
         end
      end
      chk("stall_accept", {31'd0, got}, 32'd1);
      @(posedge clk); #1;
      core_req_valid = 1'b0;
      stall = 0;
      got   = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_req_valid) begin
            chk("stall_addr_stable", mem_req_addr, 32'h0000_0440);
            if (mem_req_ready) begin
               got = 1'b1;
               break;
            end else begin
               stall++;
            end
         end
      end
      chk("stall_handshake", {31'd0, got}, 32'd1);
      chk("stall_cycles", stall, 32'd5);
      chk("stall_miss_cnt", miss_count, 32'd6);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_ctrl", {27'd0, core_req_ready, core_resp_valid, core_resp_err, mem_req_valid, 1'b0}, 32'd0);
      chk("midrst_mem_addr", mem_req_addr, 32'h0);
      chk("midrst_hit", hit_count, 32'd0);
      chk("midrst_miss", miss_count, 32'd0);
      @(posedge clk); #1;
      rst       = 1'b0;
      req_wait  = 0;
      resp_hold = 1'b0;
      stale_req = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      read_req(32'h0000_0440, 32'h0020_0113, 1'b0, 3, 1'b1);
      wait_done();
      chk("post_rst_miss_cnt", miss_count, 32'd1);
      chk("post_rst_hit_cnt", hit_count, 32'd0);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped instruction cache between the fetch stage (upstream requester) and the instruction memory port (downstream).
- Geometry is taken from multicore_pkg: LINES_PER_BLK lines, each LINE_SIZE bits wide, holding one instruction per line.
- Accepts one fetch address at a time and returns the instruction word, either from the array on a hit or after a single-word refill from memory on a miss.
- Also provides a whole-cache invalidate and hit/miss performance counters.

Parameters:
- ADDR_W, 32: byte address width.
- LINES, multicore_pkg::LINES_PER_BLK (256): number of lines; must be a power of two.
- DATA_W, multicore_pkg::INST_SIZE (32): instruction/line width; must equal LINE_SIZE.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  level; invalidate all lines.
- core_req_valid  in  1  fetch request present.
- core_req_ready  out  1  cache can accept a request this cycle.
- core_addr  in  ADDR_W  byte address of the instruction.
- core_resp_valid  out  1  single-cycle pulse; response data valid.
- core_resp_data  out  DATA_W  instruction word.
- core_resp_err  out  1  misaligned request; qualified by core_resp_valid.
- mem_req_valid  out  1  refill request.
- mem_req_ready  in  1  memory accepts the refill request.
- mem_req_addr  out  ADDR_W  word-aligned refill address.
- mem_resp_valid  in  1  refill data valid.
- mem_resp_data  in  DATA_W  refill word.
- hit_count  out  32  saturating count of hits.
- miss_count  out  32  saturating count of misses.

Behaviour:
- Address split:
  - offset = addr[OFFSET-1:0], with OFFSET = multicore_pkg::OFFSET = 2.
  - index = addr[OFFSET+IDX_W-1:OFFSET], with IDX_W = clog2(LINES) = 8.
  - tag = the remaining upper bits (22 at defaults).
- Storage: a valid bit per line (flops), plus tag and data arrays. Valid bits clear on rst. The tag and data arrays are not reset.
- Reset values: FSM = IDLE; every output port = 0, including both counters and core_req_ready.
- core_req_ready = 1 only when the state is IDLE and flush = 0. A request is accepted when core_req_valid && core_req_ready.
- Responses have no backpressure; the fetch stage must consume core_resp_valid in the cycle it is asserted.
- FSM states:
  - IDLE:
    - flush=1: clear all valid bits in one cycle; stay in IDLE; do not accept a request.
    - Accepted request: register the address and go to LOOKUP.
  - LOOKUP, with three outcomes:
    - Misaligned (offset != 0): core_resp_valid=1, err=1, data=0. No counter change, no memory access. Go to IDLE.
    - Hit (valid and tag match): core_resp_valid=1, data=array word, err=0. hit_count++. Go to IDLE. Hit latency is accept cycle N, response at N+1.
    - Miss: miss_count++. Go to REFILL_REQ.
  - REFILL_REQ: mem_req_valid=1 and mem_req_addr = {addr[ADDR_W-1:OFFSET], 0}. Both are held stable until mem_req_ready=1, then go to REFILL_WAIT.
  - REFILL_WAIT: on mem_resp_valid, write the data and tag, set the valid bit, and drive core_resp_valid=1 with data = mem_resp_data in the same cycle. Go to IDLE.
- Miss latency is 3 + memory request wait + memory response wait cycles from accept to response. With zero-wait memory (ready already high in REFILL_REQ, response in the first REFILL_WAIT cycle): accept N, response N+3.
- mem_resp_valid outside REFILL_WAIT is ignored.
- flush is sampled only in IDLE. While busy it is deferred; the refill in progress completes and its line is then invalidated by the flush.
- flush and core_req_valid in the same cycle: flush wins, and the request stays pending with ready=0.
- rst mid-refill: return to IDLE and clear valid bits. Any late memory response is ignored, and the memory side must be reset in the same domain.
- Counters saturate at 0xFFFF_FFFF and do not wrap.
- core_resp_data is 0 whenever core_resp_valid = 0.

Decomposition:
- Add to multicore_pkg:
  - IDX_W = $clog2(LINES_PER_BLK).
  - TAG_W = 32 - IDX_W - OFFSET.
  - typedef enum logic [1:0] {IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT} icache_state_t.
- Sub-module icache_array: single-port synchronous tag+data RAM with 1-cycle read and write-first behaviour; lets the design map to BRAM.
- Valid bits, FSM and counters stay in icache_dm.

Test Plan:
- Reset then cold read at 0x0000_0040, memory returns 0x0010_0093 → mem_req_addr=0x40; core_resp_data=0x0010_0093; miss_count=1; zero-wait response at accept+3.
- Repeat the read of 0x40 → response at accept+1 with data 0x0010_0093, no mem_req_valid, hit_count=1.
- Read 0x0000_0440 (same index 0x10, different tag) after the 0x40 read → miss and refill. A following read of 0x40 misses again, proving eviction.
- Read 0x0000_0042 → core_resp_valid with err=1 and data=0 at accept+1; no memory request; counters unchanged.
- Pulse flush in IDLE, then read 0x40 → miss. Flush and core_req_valid asserted together → core_req_ready=0 that cycle; the request is accepted the following cycle.
- Hold mem_req_ready=0 for 5 cycles, then assert rst in REFILL_WAIT and drive a stale mem_resp_valid afterward → FSM returns to IDLE, all outputs 0, and the stale response is ignored (the next read of that address misses).
